// File: rtl/mul_pkg.sv
// Shared definitions for the two-requester shift-add multiplier scheduler.
package mul_pkg;

  localparam int N = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/mul_step.sv
// One shift-add step: conditionally adds the aligned multiplicand into the accumulator.
module mul_step #(
  parameter int N = 16
) (
  input  logic [2*N-1:0] acc,
  input  logic [2*N-1:0] mcand,
  input  logic           mbit,
  output logic [2*N-1:0] acc_next
);

  always_comb begin
    acc_next = mbit ? (acc + mcand) : acc;
  end

endmodule

// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one sequential N-step multiplier between two requesters.
module mul_sched
  import mul_pkg::*;
#(
  parameter int N = mul_pkg::N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output req_id_t      rsp_id,
  output logic [N-1:0] rsp_lo,
  output logic [N-1:0] rsp_hi,
  output logic         busy
);

  localparam int CW = $clog2(N) + 1;

  state_t         state, state_next;
  logic [2*N-1:0] acc, mcand, acc_next;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  cnt;
  req_id_t        cur_id, last_id;
  logic           grant0, grant1, grant, last_step;

  // last_id == 1 means requester 0 wins a tie next time
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && state == IDLE) begin
      if (req0_valid && (!req1_valid || last_id == 1'b1)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign grant      = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign last_step  = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (grant)     state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  mul_step #(.N(N)) u_step (
    .acc      (acc),
    .mcand    (mcand),
    .mbit     (mplier[0]),
    .acc_next (acc_next)
  );

  // Result registers only load on the final step so they hold between operations
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      cur_id  <= 1'b0;
      last_id <= 1'b1;
      rsp_lo  <= '0;
      rsp_hi  <= '0;
      rsp_id  <= 1'b0;
    end else if (grant) begin
      acc     <= '0;
      mcand   <= {{N{1'b0}}, (grant1 ? req1_a : req0_a)};
      mplier  <= grant1 ? req1_b : req0_b;
      cnt     <= CW'(N);
      cur_id  <= grant1;
      last_id <= grant1;
    end else if (state == RUN) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
      if (last_step) begin
        rsp_lo <= acc_next[N-1:0];
        rsp_hi <= acc_next[2*N-1:N];
        rsp_id <= cur_id;
      end
    end
  end

endmodule

// File: tb/tb_mul_sched.sv
// Self-checking bench for mul_sched: scenario tasks with a queue of expected responses.
module tb_mul_sched;
  import mul_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready, busy;
  req_id_t      rsp_id;
  logic [W-1:0] rsp_lo, rsp_hi;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic          id;
    logic [2*W-1:0] prod;
  } exp_t;

  exp_t exp_q[$];

  mul_sched #(.N(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_lo     (rsp_lo),
    .rsp_hi     (rsp_hi),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    return (2*W)'(a) * (2*W)'(b);
  endfunction

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic do_reset();
    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_grant(output logic gid, output int gc, output bit ok);
    ok  = 1'b0;
    gid = 1'b0;
    gc  = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if (req0_ready || req1_ready) begin
        ok  = 1'b1;
        gid = req1_ready;
        gc  = cyc;
      end
      tick();
    end
    if (ok) begin
      if (gid) req1_valid = 1'b0;
      else     req0_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(output int rc, output bit ok);
    ok = 1'b0;
    rc = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      #1;
      if (rsp_valid) begin
        ok = 1'b1;
        rc = cyc;
      end else begin
        tick();
      end
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    req0_valid = 1'b1; req0_a = 16'h0003; req0_b = 16'h0004;
    req1_valid = 1'b1; req1_a = 16'h0005; req1_b = 16'h0006;
    rsp_ready  = 1'b0;
    tick();
    tick();
    #1;
    tests++; if (req0_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_ready0: got %b expected 0", req0_ready); end
    tests++; if (req1_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_ready1: got %b expected 0", req1_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    tests++; if (rsp_lo !== 16'h0000) begin fails++; $display("[TB] FAIL reset_rsp_lo: got %h expected 0000", rsp_lo); end
    tests++; if (rsp_hi !== 16'h0000) begin fails++; $display("[TB] FAIL reset_rsp_hi: got %h expected 0000", rsp_hi); end
    tests++; if (rsp_id !== 1'b0) begin fails++; $display("[TB] FAIL reset_rsp_id: got %b expected 0", rsp_id); end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic gid; int gc, rc; bit ok; exp_t e;
    req0_a = 16'd3; req0_b = 16'd5; req0_valid = 1'b1;
    exp_q.push_back('{id: 1'b0, prod: ref_mul(16'd3, 16'd5)});
    wait_grant(gid, gc, ok);
    tests++;
    if (!ok) begin fails++; $display("[TB] FAIL basic_grant: got timeout expected grant"); exp_q.delete(); return; end
    if (gid !== 1'b0) begin fails++; $display("[TB] FAIL basic_grant_id: got %b expected 0", gid); end
    wait_rsp(rc, ok);
    tests++;
    if (!ok) begin fails++; $display("[TB] FAIL basic_rsp: got timeout expected response"); exp_q.delete(); return; end
    if (rc !== gc + W + 1) begin fails++; $display("[TB] FAIL basic_latency: got %0d expected %0d", rc - gc, W + 1); end
    e = exp_q.pop_front();
    tests++; if (rsp_lo !== 16'h000F) begin fails++; $display("[TB] FAIL basic_lo: got %h expected 000f", rsp_lo); end
    tests++; if (rsp_hi !== 16'h0000) begin fails++; $display("[TB] FAIL basic_hi: got %h expected 0000", rsp_hi); end
    tests++; if ({rsp_hi, rsp_lo} !== e.prod) begin fails++; $display("[TB] FAIL basic_prod: got %h expected %h", {rsp_hi, rsp_lo}, e.prod); end
    tests++; if (rsp_id !== e.id) begin fails++; $display("[TB] FAIL basic_id: got %b expected %b", rsp_id, e.id); end
    tests++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL basic_busy: got %b expected 1", busy); end
    consume();
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL basic_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_max_and_zero();
    logic gid; int gc, rc; bit ok; exp_t e;
    logic [W-1:0] as[2], bs[2];
    as[0] = 16'hFFFF; bs[0] = 16'hFFFF;
    as[1] = 16'h0000; bs[1] = 16'h1234;
    for (int i = 0; i < 2; i++) begin
      req1_a = as[i]; req1_b = bs[i]; req1_valid = 1'b1;
      exp_q.push_back('{id: 1'b1, prod: ref_mul(as[i], bs[i])});
      wait_grant(gid, gc, ok);
      tests++;
      if (!ok) begin fails++; $display("[TB] FAIL maxzero_grant: got timeout expected grant"); exp_q.delete(); return; end
      if (gid !== 1'b1) begin fails++; $display("[TB] FAIL maxzero_grant_id: got %b expected 1", gid); end
      wait_rsp(rc, ok);
      tests++;
      if (!ok) begin fails++; $display("[TB] FAIL maxzero_rsp: got timeout expected response"); exp_q.delete(); return; end
      if (rc !== gc + W + 1) begin fails++; $display("[TB] FAIL maxzero_latency: got %0d expected %0d", rc - gc, W + 1); end
      e = exp_q.pop_front();
      tests++; if ({rsp_hi, rsp_lo} !== e.prod) begin fails++; $display("[TB] FAIL maxzero_prod: got %h expected %h", {rsp_hi, rsp_lo}, e.prod); end
      tests++; if (rsp_id !== e.id) begin fails++; $display("[TB] FAIL maxzero_id: got %b expected %b", rsp_id, e.id); end
      consume();
    end
  endtask

  task automatic test_arbitration();
    logic gid; int gc, rc; bit ok; exp_t e;
    do_reset();
    req0_a = 16'd7; req0_b = 16'd9; req0_valid = 1'b1;
    req1_a = 16'd2; req1_b = 16'd8; req1_valid = 1'b1;
    exp_q.push_back('{id: 1'b0, prod: 32'd63});
    exp_q.push_back('{id: 1'b1, prod: 32'd16});
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        req0_a = 16'h0011; req0_b = 16'h0022; req0_valid = 1'b1;
        req1_a = 16'h0033; req1_b = 16'h0044; req1_valid = 1'b1;
        exp_q.push_back('{id: 1'b0, prod: ref_mul(16'h0011, 16'h0022)});
        exp_q.push_back('{id: 1'b1, prod: ref_mul(16'h0033, 16'h0044)});
      end
      wait_grant(gid, gc, ok);
      tests++;
      if (!ok) begin fails++; $display("[TB] FAIL arb_grant: got timeout expected grant"); exp_q.delete(); return; end
      if (gid !== exp_q[0].id) begin fails++; $display("[TB] FAIL arb_grant_id: got %b expected %b", gid, exp_q[0].id); end
      wait_rsp(rc, ok);
      tests++;
      if (!ok) begin fails++; $display("[TB] FAIL arb_rsp: got timeout expected response"); exp_q.delete(); return; end
      if (rc !== gc + W + 1) begin fails++; $display("[TB] FAIL arb_latency: got %0d expected %0d", rc - gc, W + 1); end
      e = exp_q.pop_front();
      tests++; if ({rsp_hi, rsp_lo} !== e.prod) begin fails++; $display("[TB] FAIL arb_prod: got %h expected %h", {rsp_hi, rsp_lo}, e.prod); end
      tests++; if (rsp_id !== e.id) begin fails++; $display("[TB] FAIL arb_id: got %b expected %b", rsp_id, e.id); end
      consume();
    end
  endtask

  task automatic test_hold();
    logic gid; int gc, rc, cc; bit ok; exp_t e;
    logic [2*W-1:0] p;
    p = ref_mul(16'h1234, 16'h0056);
    req0_a = 16'h1234; req0_b = 16'h0056; req0_valid = 1'b1;
    exp_q.push_back('{id: 1'b0, prod: p});
    wait_grant(gid, gc, ok);
    tests++;
    if (!ok) begin fails++; $display("[TB] FAIL hold_grant: got timeout expected grant"); exp_q.delete(); return; end
    req0_a = 16'h00FF; req0_b = 16'h0101; req0_valid = 1'b1;
    wait_rsp(rc, ok);
    tests++;
    if (!ok) begin fails++; $display("[TB] FAIL hold_rsp: got timeout expected response"); exp_q.delete(); return; end
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      tests++; if (rsp_valid !== 1'b1) begin fails++; $display("[TB] FAIL hold_valid: got %b expected 1", rsp_valid); end
      tests++; if ({rsp_hi, rsp_lo} !== e.prod) begin fails++; $display("[TB] FAIL hold_prod: got %h expected %h", {rsp_hi, rsp_lo}, e.prod); end
      tests++; if (rsp_id !== e.id) begin fails++; $display("[TB] FAIL hold_id: got %b expected %b", rsp_id, e.id); end
      tests++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL hold_busy: got %b expected 1", busy); end
      tests++; if (req0_ready !== 1'b0) begin fails++; $display("[TB] FAIL hold_no_grant: got %b expected 0", req0_ready); end
    end
    rsp_ready = 1'b1;
    #1;
    cc = cyc;
    tests++; if (req0_ready !== 1'b0) begin fails++; $display("[TB] FAIL hold_consume_cycle_ready: got %b expected 0", req0_ready); end
    tick();
    rsp_ready = 1'b0;
    exp_q.push_back('{id: 1'b0, prod: ref_mul(16'h00FF, 16'h0101)});
    wait_grant(gid, gc, ok);
    tests++;
    if (!ok) begin fails++; $display("[TB] FAIL hold_regrant: got timeout expected grant"); exp_q.delete(); return; end
    if (gc !== cc + 1) begin fails++; $display("[TB] FAIL hold_regrant_cycle: got %0d expected %0d", gc, cc + 1); end
    wait_rsp(rc, ok);
    tests++;
    if (!ok) begin fails++; $display("[TB] FAIL hold_rsp2: got timeout expected response"); exp_q.delete(); return; end
    e = exp_q.pop_front();
    if ({rsp_hi, rsp_lo} !== e.prod) begin fails++; $display("[TB] FAIL hold_prod2: got %h expected %h", {rsp_hi, rsp_lo}, e.prod); end
    consume();
  endtask

  task automatic test_reset_mid_run();
    logic gid; int gc, seen; bit ok;
    req0_a = 16'h00AB; req0_b = 16'h00CD; req0_valid = 1'b1;
    wait_grant(gid, gc, ok);
    tests++;
    if (!ok) begin fails++; $display("[TB] FAIL midrst_grant: got timeout expected grant"); return; end
    tick();
    tick();
    #1;
    tests++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL midrst_busy_run: got %b expected 1", busy); end
    rst = 1'b1;
    tick();
    #1;
    rst = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL midrst_rsp_valid: got %b expected 0", rsp_valid); end
    tests++; if (rsp_lo !== 16'h0000) begin fails++; $display("[TB] FAIL midrst_rsp_lo: got %h expected 0000", rsp_lo); end
    tests++; if (rsp_hi !== 16'h0000) begin fails++; $display("[TB] FAIL midrst_rsp_hi: got %h expected 0000", rsp_hi); end
    seen = 0;
    for (int i = 0; i < W + 6; i++) begin
      tick();
      #1;
      if (rsp_valid === 1'b1 || busy === 1'b1) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("[TB] FAIL midrst_stale: got %0d active cycles expected 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic gid, eid, exp_last, pend0, pend1; int gc, rc; bit ok; exp_t e;
    do_reset();
    exp_last = 1'b1;
    pend0 = 1'b0;
    pend1 = 1'b0;
    for (int t = 0; t < 16; t++) begin
      if (!pend0 && $urandom_range(0, 3) != 0) begin
        req0_a = rand_op(); req0_b = rand_op(); req0_valid = 1'b1; pend0 = 1'b1;
      end
      if (!pend1 && $urandom_range(0, 3) != 0) begin
        req1_a = rand_op(); req1_b = rand_op(); req1_valid = 1'b1; pend1 = 1'b1;
      end
      if (!pend0 && !pend1) begin
        req0_a = rand_op(); req0_b = rand_op(); req0_valid = 1'b1; pend0 = 1'b1;
      end
      eid = (pend0 && pend1) ? ~exp_last : pend1;
      exp_q.push_back('{id: eid, prod: eid ? ref_mul(req1_a, req1_b) : ref_mul(req0_a, req0_b)});
      wait_grant(gid, gc, ok);
      tests++;
      if (!ok) begin fails++; $display("[TB] FAIL b2b_grant: got timeout expected grant"); exp_q.delete(); return; end
      if (gid !== eid) begin fails++; $display("[TB] FAIL b2b_grant_id: got %b expected %b", gid, eid); end
      exp_last = eid;
      if (gid) pend1 = 1'b0;
      else     pend0 = 1'b0;
      wait_rsp(rc, ok);
      tests++;
      if (!ok) begin fails++; $display("[TB] FAIL b2b_rsp: got timeout expected response"); exp_q.delete(); return; end
      if (rc !== gc + W + 1) begin fails++; $display("[TB] FAIL b2b_latency: got %0d expected %0d", rc - gc, W + 1); end
      e = exp_q.pop_front();
      tests++; if ({rsp_hi, rsp_lo} !== e.prod) begin fails++; $display("[TB] FAIL b2b_prod: got %h expected %h", {rsp_hi, rsp_lo}, e.prod); end
      tests++; if (rsp_id !== e.id) begin fails++; $display("[TB] FAIL b2b_id: got %b expected %b", rsp_id, e.id); end
      for (int h = 0; h < int'($urandom_range(0, 2)); h++) tick();
      consume();
    end
  endtask

  initial begin
    rst        = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    rsp_ready  = 1'b0;
    test_reset();
    test_basic();
    test_max_and_zero();
    test_arbitration();
    test_hold();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_sched.md
MUL_SCHED -- requirements
Module: mul_sched

Interface
REQ-001 Parameter N, default 16: operand width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operand pair.
REQ-005 req0_ready  output  1  requester 0 pair accepted this cycle.
REQ-006 req0_a, req0_b  input  N each  requester 0 multiplicand and multiplier.
REQ-007 req1_valid, req1_ready, req1_a, req1_b: same as REQ-004..006 for requester 1.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer accepts result.
REQ-010 rsp_id  output  1  requester index that owns the result.
REQ-011 rsp_lo  output  N  product bits [N-1:0].
REQ-012 rsp_hi  output  N  product bits [2N-1:N], the carry-out word.
REQ-013 busy  output  1  high in RUN or DONE.

Function
REQ-014 Product is unsigned, full width 2N; no truncation or overflow flag.
REQ-015 FSM states IDLE, RUN, DONE; transitions IDLE->RUN on grant, RUN->DONE after N step cycles, DONE->IDLE on rsp_valid&&rsp_ready.
REQ-016 Grant only in IDLE; at most one of req0_ready/req1_ready high per cycle; readyX is high only when reqX_valid is high and X is granted.
REQ-017 Arbitration round-robin: when both are valid, grant the requester not granted last; after reset, requester 0 has priority.
REQ-018 On grant, latch a, b and id; clear the 2N-bit accumulator; load step counter with N.
REQ-019 RUN: one shift-add step per cycle, multiplier LSB first; if the bit is 1, add the shifted multiplicand to the accumulator; decrement the counter.
REQ-020 Fixed latency: a grant in cycle t gives rsp_valid in cycle t+N+1, independent of operand values, zero operands included.
REQ-021 In DONE, rsp_valid, rsp_id, rsp_lo and rsp_hi hold stable until rsp_ready; there is no time-out.
REQ-022 Outside DONE, rsp_valid is 0; rsp_lo, rsp_hi and rsp_id hold their last values.
REQ-023 No new grant in the cycle the response is consumed; the earliest next grant is the following cycle, in IDLE.
REQ-024 Request inputs are ignored outside IDLE; requesters hold valid and operands until ready.

Reset
REQ-025 rst has priority over all other inputs. In the cycle after rst is asserted: state IDLE, all readies 0, rsp_valid 0, busy 0, rsp_lo/rsp_hi 0, rsp_id 0, last-grant pointer set to favour requester 0.
REQ-026 Reset during RUN or DONE discards the operation; no response is produced for it.

Structure
REQ-027 Package mul_pkg holds N, the state enum type (IDLE, RUN, DONE) and the requester-id type.
REQ-028 One combinational sub-module, mul_step: accumulator, shifted multiplicand and multiplier bit in; next accumulator out.
REQ-029 Arbiter, FSM and counter live in mul_sched; the counter is clog2(N)+1 bits wide.

Verification
REQ-030 req0 3*5 -> rsp_valid N+1 cycles after grant, rsp_lo=0x000F, rsp_hi=0x0000, rsp_id=0.
REQ-031 req1 0xFFFF*0xFFFF -> rsp_lo=0x0001, rsp_hi=0xFFFE, rsp_id=1; 0*0x1234 -> 0/0 with unchanged latency.
REQ-032 Both valid in the first cycle after reset, req0 7*9 and req1 2*8 -> req0 granted first (63); req1 granted next (16); a further simultaneous pair -> req0 granted (round-robin).
REQ-033 rsp_ready held low 5 cycles in DONE -> outputs stable and busy=1; req0_valid high throughout -> no grant until the cycle after consumption.
REQ-034 rst asserted mid-RUN -> next cycle IDLE, busy=0, rsp_valid=0; no stale response afterwards.
REQ-035 Random back-to-back traffic on both ports -> every product matches the reference model; response order equals grant order.
